// File: rtl/imm_extend_pkg.sv
// Shared decode definitions for the immediate-extension stage:
// mode encodings and default widths.
package imm_extend_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT   = 2'b00,
    IMM_ZEXT   = 2'b01,
    IMM_UPPER  = 2'b10,
    IMM_BRANCH = 2'b11
  } imm_mode_e;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_TAG_W = 5;

endpackage

// File: rtl/imm_extend_fn.sv
// Combinational immediate extender: maps (imm, mode) to an OUT_W-bit operand.
module imm_extend_fn
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  imm_i,
  input  imm_mode_e        mode_i,
  output logic [OUT_W-1:0] ext_o
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

  always_comb begin
    ext_o = '0;
    unique case (mode_i)
      IMM_SEXT:   ext_o = sext;
      IMM_ZEXT:   ext_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
      IMM_UPPER:  ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
      // Branch offsets are word-scaled; the two bits shifted out simply wrap.
      IMM_BRANCH: ext_o = {sext[OUT_W-3:0], 2'b00};
      default:    ext_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a two-entry skid buffer;
// in_ready depends only on registered state, never on out_ready.
module imm_extend_stage
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("imm_extend_stage: OUT_W must be at least IN_W+2");
  end

  logic [OUT_W-1:0] ext;

  imm_extend_fn #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_fn (
    .imm_i  (in_imm),
    .mode_i (imm_mode_e'(in_mode)),
    .ext_o  (ext)
  );

  logic             m_vld_q, m_vld_d;
  logic             s_vld_q, s_vld_d;
  logic [OUT_W-1:0] m_imm_q, m_imm_d, s_imm_q, s_imm_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;
  logic             acc, pop;

  assign in_ready  = ~s_vld_q;
  assign out_valid = m_vld_q;
  assign out_imm   = m_imm_q;
  assign out_tag   = m_tag_q;

  assign acc = in_valid & ~s_vld_q;
  assign pop = m_vld_q & out_ready;

  always_comb begin
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    m_imm_d = m_imm_q;
    m_tag_d = m_tag_q;
    s_imm_d = s_imm_q;
    s_tag_d = s_tag_q;
    // Flush wins over any same-cycle accept; data may stay stale.
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q) begin
      if (acc) begin
        m_vld_d = 1'b1;
        m_imm_d = ext;
        m_tag_d = in_tag;
      end
    end else if (!s_vld_q) begin
      if (acc && pop) begin
        m_imm_d = ext;
        m_tag_d = in_tag;
      end else if (acc) begin
        s_vld_d = 1'b1;
        s_imm_d = ext;
        s_tag_d = in_tag;
      end else if (pop) begin
        m_vld_d = 1'b0;
      end
    end else if (pop) begin
      m_imm_d = s_imm_q;
      m_tag_d = s_tag_q;
      s_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_imm_q <= '0;
      m_tag_q <= '0;
      s_imm_q <= '0;
      s_tag_q <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_imm_q <= m_imm_d;
      m_tag_q <= m_tag_d;
      s_imm_q <= s_imm_d;
      s_tag_q <= s_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: directed scenarios plus random traffic against a
// queue-based reference model, and a 12->64 instance for wide-format values.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [11:0] w_in_imm = '0;
  logic [1:0]  w_in_mode = '0;
  logic [4:0]  w_in_tag = '0;
  logic        w_out_valid;
  logic [63:0] w_out_imm;
  logic [4:0]  w_out_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
  } item_t;
  item_t q[$];

  always #5 clk = ~clk;

  imm_extend_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_tag   (out_tag)
  );

  imm_extend_stage #(.IN_W(12), .OUT_W(64), .TAG_W(5)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_imm    (w_in_imm),
    .in_mode   (w_in_mode),
    .in_tag    (w_in_tag),
    .out_valid (w_out_valid),
    .out_ready (1'b1),
    .out_imm   (w_out_imm),
    .out_tag   (w_out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_ext(input int in_w, input int out_w,
                                          input logic [63:0] imm, input int mode);
    longint      s;
    logic [63:0] mask;
    logic [63:0] r;
    s = longint'(imm);
    if (imm[in_w-1]) s = s - (longint'(1) << in_w);
    mask = (out_w == 64) ? '1 : ((64'd1 << out_w) - 64'd1);
    case (mode)
      0:       r = logic'(1) ? (64'(s) & mask) : '0;
      1:       r = imm;
      2:       r = (imm << (out_w - in_w)) & mask;
      default: r = 64'(s * 4) & mask;
    endcase
    return r;
  endfunction

  task automatic check_state();
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("out_imm", {32'd0, out_imm}, q[0].imm);
      chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
    end
  endtask

  // Called at a negedge: drive, let one clock edge pass, update model, check.
  task automatic step(input logic iv, input logic [15:0] imm, input logic [1:0] mode,
                      input logic [4:0] tag, input logic ordy, input logic fl);
    bit acc, pop;
    item_t it;
    in_valid  = iv;
    in_imm    = imm;
    in_mode   = mode;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    it.imm = ref_ext(16, 32, {48'd0, imm}, int'(mode));
    it.tag = tag;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    @(negedge clk);
    check_state();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_imm", {32'd0, out_imm}, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);

    // Four formats on 0x8001, each visible one cycle after acceptance.
    step(1, 16'h8001, 2'b00, 5'd1, 1, 0);
    chk("sext_8001", {32'd0, out_imm}, 64'hFFFF8001);
    step(1, 16'h8001, 2'b01, 5'd2, 1, 0);
    chk("zext_8001", {32'd0, out_imm}, 64'h00008001);
    step(1, 16'h8001, 2'b10, 5'd3, 1, 0);
    chk("upper_8001", {32'd0, out_imm}, 64'h80010000);
    step(1, 16'h8001, 2'b11, 5'd4, 1, 0);
    chk("branch_8001", {32'd0, out_imm}, 64'hFFFE0004);
    step(0, '0, '0, '0, 1, 0);

    // Back-to-back stream, tags 0..7.
    for (int i = 0; i < 8; i++) begin
      step(1, 16'($urandom), 2'($urandom), 5'(i), 1, 0);
      chk("stream_tag", {59'd0, out_tag}, 64'(i));
      chk("stream_rdy", {63'd0, in_ready}, 64'd1);
    end
    step(0, '0, '0, '0, 1, 0);

    // Stall with three items offered, then drain.
    step(1, 16'h0011, 2'b01, 5'd20, 0, 0);
    step(1, 16'h0022, 2'b01, 5'd21, 0, 0);
    chk("stall_full_rdy", {63'd0, in_ready}, 64'd0);
    step(1, 16'h0033, 2'b01, 5'd22, 0, 0);
    chk("stall_hold_tag", {59'd0, out_tag}, 64'd20);
    for (int i = 0; i < 4; i++) step(1, 16'h0033, 2'b01, 5'd22, 1, 0);
    step(0, '0, '0, '0, 1, 0);

    // Flush while FULL with a simultaneous offer and pop.
    step(1, 16'h1234, 2'b00, 5'd30, 0, 0);
    step(1, 16'h5678, 2'b00, 5'd31, 0, 0);
    step(1, 16'h9ABC, 2'b00, 5'd29, 1, 1);
    chk("flush_vld", {63'd0, out_valid}, 64'd0);
    chk("flush_rdy", {63'd0, in_ready}, 64'd1);
    step(0, '0, '0, '0, 1, 0);

    // Async reset between edges while FULL.
    step(1, 16'h0101, 2'b01, 5'd11, 0, 0);
    step(1, 16'h0202, 2'b01, 5'd12, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_vld", {63'd0, out_valid}, 64'd0);
    chk("arst_rdy", {63'd0, in_ready}, 64'd1);
    #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    step(1, 16'h0909, 2'b01, 5'd9, 1, 0);
    chk("arst_first_tag", {59'd0, out_tag}, 64'd9);
    step(0, '0, '0, '0, 1, 0);

    // Wide instance.
    w_in_valid = 1'b1;
    w_in_imm   = 12'h800;
    w_in_mode  = 2'b11;
    w_in_tag   = 5'd3;
    step(0, '0, '0, '0, 1, 0);
    chk("w_branch", w_out_imm, 64'hFFFFFFFFFFFFE000);
    chk("w_branch_model", w_out_imm, ref_ext(12, 64, 64'h800, 3));
    w_in_mode = 2'b10;
    step(0, '0, '0, '0, 1, 0);
    chk("w_upper", w_out_imm, 64'h8000000000000000);
    chk("w_vld", {63'd0, w_out_valid}, 64'd1);
    w_in_valid = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom), 5'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Parametrised, registered immediate-extension stage for the decode pipeline. It accepts an IN_W-bit immediate, a 2-bit mode and a passthrough tag, and produces an OUT_W-bit operand in one of four formats: sign, zero, upper-load, or branch-offset. The result carries a valid/ready handshake and passes through a two-entry skid buffer, so decode can be stalled by execute without a combinational ready path. It replaces the purely combinational 16→32 sign extender between decode and the ID/EX register.

## Interface
- IN_W, 16, immediate input width
- OUT_W, 32, extended output width; must satisfy OUT_W ≥ IN_W+2
- TAG_W, 5, width of sideband tag (e.g. destination register) carried alongside
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous pipeline flush; empties the stage
- in_valid  in  1  upstream holds a valid immediate
- in_ready  out  1  stage can accept this cycle
- in_imm  in  IN_W  raw immediate field
- in_mode  in  2  00 SEXT, 01 ZEXT, 10 UPPER, 11 BRANCH
- in_tag  in  TAG_W  sideband, passed unchanged
- out_valid  out  1  out_imm/out_tag valid
- out_ready  in  1  downstream accepts this cycle
- out_imm  out  OUT_W  extended immediate
- out_tag  out  TAG_W  tag matching out_imm

## Operation
- Extension, computed on input, before registering:
  - SEXT: {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
  - ZEXT: {(OUT_W-IN_W){0}, imm}.
  - UPPER: imm placed in bits [OUT_W-1 : OUT_W-IN_W], zeros below. For 16/32 this is LUI.
  - BRANCH: sign-extend to OUT_W, then shift left 2; the top two bits are discarded (wrap, no saturation).
- Storage: main register (M) drives outputs; skid register (S) catches one item when M is full and downstream stalls.
- State, from {M.valid, S.valid}:
  - EMPTY (0,0)
  - ONE (1,0)
  - FULL (1,1)
  - (0,1) is illegal and unreachable.
- in_ready = ~S.valid. It is a register output only; there is no combinational path from out_ready.
- Transitions (acc = in_valid & in_ready, pop = out_valid & out_ready):
  - EMPTY: acc → ONE (M ← input).
  - ONE:
    - acc & pop → ONE (M ← input).
    - acc & ~pop → FULL (S ← input).
    - ~acc & pop → EMPTY.
  - FULL (acc impossible):
    - pop → ONE (M ← S).
    - ~pop → hold.
- Ordering is strictly FIFO; no item is dropped or duplicated.
- flush: next edge goes to EMPTY. Flush beats a simultaneous acc and pop: input is discarded and the pop still counts as consumed by downstream. Data registers may keep stale values but out_valid=0.
- Illegal mode values: none, because all four encodings are defined.

## Timing
- Latency is 1 cycle: input accepted at edge N appears on out_* after edge N when the stage was EMPTY, or after a same-cycle pop from ONE.
- Throughput is 1 item/cycle while out_ready=1.
- Under stall, at most 2 items are held. in_ready falls the cycle after the second item is accepted.
- Reset (async assert, deassert synchronous to clk by the top level):
  - out_valid=0, in_ready=1, out_imm=0, out_tag=0.
  - State EMPTY.
- Reset asserted mid-transfer drops all held items immediately, without waiting for a clock edge.
- out_imm/out_tag remain stable while out_valid=1 & out_ready=0.

## Structure
- Shared decode package: mode encodings IMM_SEXT/IMM_ZEXT/IMM_UPPER/IMM_BRANCH, the 2-bit mode typedef, and the default widths.
- Sub-module imm_extend_fn: combinational, parametrised by IN_W/OUT_W, maps (imm, mode) → extended value. The top level holds the skid buffer and control.
- Elaboration-time check: error if OUT_W < IN_W+2.

## Test plan
- Modes at defaults, out_ready=1:
  - imm 0x8001, SEXT → 0xFFFF8001.
  - ZEXT → 0x00008001.
  - UPPER → 0x80010000.
  - BRANCH → 0xFFFE0004.
  - Each appears one cycle after acceptance.
- Back-to-back stream of 8 items with tags 0..7 and out_ready=1 → out_valid continuous, in_ready stays 1, tags emerge in order.
- Stall: out_ready=0 while 3 items are offered → the first two are accepted and in_ready=0 from the cycle after the second. Raising out_ready → items drain in order, then the third is accepted.
- Flush while FULL, with in_valid=1 and out_ready=1 in the same cycle → next cycle out_valid=0, in_ready=1, the offered item is not emitted.
- Async reset pulsed between edges while FULL → out_valid=0 and in_ready=1 immediately; after release, the first accepted item (tag 9) is the next output.
- Parametrised instance IN_W=12, OUT_W=64, imm 0x800:
  - BRANCH → 0xFFFFFFFFFFFFE000.
  - UPPER → 0x8000000000000000.
